// File: rtl/ahblite_pkg.sv
// ahblite_pkg: shared AHB-Lite encodings for the master arbiter slice.
//   HTRANS_* : transfer type codes
//   HRESP_*  : response codes
//   HBURST_SINGLE : single-beat burst code
package ahblite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // Address-phase control bits other than HADDR:
  // HTRANS(2) HWRITE(1) HSIZE(3) HBURST(3) HPROT(4) HMASTLOCK(1)
  localparam int unsigned AP_CTRL_W = 14;

  // A SEQ beat that no longer directly follows its predecessor on the bus
  // has to restart the burst as NONSEQ.
  function automatic logic [1:0] seq_fix(input logic [1:0] ht, input logic restart);
    return (restart && ht == HTRANS_SEQ) ? HTRANS_NONSEQ : ht;
  endfunction

endpackage

// File: rtl/ahblite_arb_hold.sv
// ahblite_arb_hold: per-port address-phase holding stage.
// Keeps the address phase of a master that lost arbitration, stalls that
// master while the transfer is parked, and selects hold vs live fields.
// Ports:
//   HCLK, HRESETn : clock, synchronous active-low reset
//   live          : packed live address phase, HTRANS in [1:0]
//   take          : this port granted and M_HREADY high this cycle
//   dp_mine       : this port owns the current data phase
//   m_hready      : muxed slave HREADY
//   pend          : a parked transfer is waiting
//   hready        : HREADY returned to this master
//   req           : this port requests the bus
//   fwd           : address phase offered to the shared bus
module ahblite_arb_hold
  import ahblite_pkg::*;
#(
  parameter int W = 46
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  input  logic [W-1:0] live,
  input  logic         take,
  input  logic         dp_mine,
  input  logic         m_hready,
  output logic         pend,
  output logic         hready,
  output logic         req,
  output logic [W-1:0] fwd
);

  logic [W-1:0] hold;
  logic         live_req;

  // A parked master is stalled; otherwise it sees its own data phase only.
  assign hready   = pend ? 1'b0 : (dp_mine ? m_hready : 1'b1);
  assign live_req = hready && (live[1:0] != HTRANS_IDLE) && (live[1:0] != HTRANS_BUSY);
  assign req      = pend | live_req;
  assign fwd      = pend ? hold : live;

  // The master believes its address phase completed when hready was high,
  // so a transfer that is not taken by the bus that cycle must be parked.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      pend <= 1'b0;
      hold <= '0;
    end else if (take) begin
      pend <= 1'b0;
    end else if (live_req) begin
      pend <= 1'b1;
      hold <= live;
    end
  end

endmodule

// File: rtl/ahblite_master_arbiter.sv
// ahblite_master_arbiter: two-master AHB-Lite arbiter in front of the slave
// decoder/mux. Port 0 = Cortex-M0, port 1 = DMA/debug master.
// Per-transfer arbitration, address-phase holding for the losing master,
// SEQ->NONSEQ restart on interrupted bursts, HMASTLOCK honoured, and
// HREADY/HRESP routed to the data-phase owner.
// Build option: AHBLITE_ARB_RR_EN selects round-robin on contention;
// when undefined, port 0 has fixed priority.
// Ports:
//   HCLK, HRESETn        : clock, synchronous active-low reset
//   P0_*/P1_*            : master-side AHB-Lite ports
//   M_*                  : shared bus towards decoder/slave mux
//   M_HMASTER            : current address-phase owner
module ahblite_master_arbiter
  import ahblite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [1:0]        P0_HTRANS,
  input  logic [ADDR_W-1:0] P0_HADDR,
  input  logic              P0_HWRITE,
  input  logic [2:0]        P0_HSIZE,
  input  logic [2:0]        P0_HBURST,
  input  logic [3:0]        P0_HPROT,
  input  logic              P0_HMASTLOCK,
  input  logic [DATA_W-1:0] P0_HWDATA,
  output logic              P0_HREADY,
  output logic              P0_HRESP,
  output logic [DATA_W-1:0] P0_HRDATA,
  input  logic [1:0]        P1_HTRANS,
  input  logic [ADDR_W-1:0] P1_HADDR,
  input  logic              P1_HWRITE,
  input  logic [2:0]        P1_HSIZE,
  input  logic [2:0]        P1_HBURST,
  input  logic [3:0]        P1_HPROT,
  input  logic              P1_HMASTLOCK,
  input  logic [DATA_W-1:0] P1_HWDATA,
  output logic              P1_HREADY,
  output logic              P1_HRESP,
  output logic [DATA_W-1:0] P1_HRDATA,
  output logic [1:0]        M_HTRANS,
  output logic [ADDR_W-1:0] M_HADDR,
  output logic              M_HWRITE,
  output logic [2:0]        M_HSIZE,
  output logic [2:0]        M_HBURST,
  output logic [3:0]        M_HPROT,
  output logic              M_HMASTLOCK,
  output logic [DATA_W-1:0] M_HWDATA,
  input  logic              M_HREADY,
  input  logic              M_HRESP,
  input  logic [DATA_W-1:0] M_HRDATA,
  output logic              M_HMASTER
);

  localparam int AW = ADDR_W + AP_CTRL_W;

  logic [1:0][AW-1:0] live, fwd;
  logic [1:0]         pend, hready, req, take, dp_mine;
  logic [AW-1:0]      sel;
  logic               grant, grant_q, locked, dp_valid, dp_owner;

  // Packing: {HMASTLOCK, HPROT, HBURST, HSIZE, HWRITE, HADDR, HTRANS}
  assign live[0] = {P0_HMASTLOCK, P0_HPROT, P0_HBURST, P0_HSIZE, P0_HWRITE, P0_HADDR, P0_HTRANS};
  assign live[1] = {P1_HMASTLOCK, P1_HPROT, P1_HBURST, P1_HSIZE, P1_HWRITE, P1_HADDR, P1_HTRANS};

  for (genvar n = 0; n < 2; n++) begin : g_port
    assign dp_mine[n] = dp_valid & (dp_owner == 1'(n));
    assign take[n]    = M_HREADY & (grant == 1'(n));

    ahblite_arb_hold #(.W(AW)) u_hold (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .live     (live[n]),
      .take     (take[n]),
      .dp_mine  (dp_mine[n]),
      .m_hready (M_HREADY),
      .pend     (pend[n]),
      .hready   (hready[n]),
      .req      (req[n]),
      .fwd      (fwd[n])
    );
  end

  // Locked sequences keep the bus; with no request the grant parks.
  always_comb begin
    grant = grant_q;
    if (!locked) begin
      case (req)
        2'b01:   grant = 1'b0;
        2'b10:   grant = 1'b1;
`ifdef AHBLITE_ARB_RR_EN
        2'b11:   grant = ~grant_q;
`else
        2'b11:   grant = 1'b0;
`endif
        default: grant = grant_q;
      endcase
    end
  end

  assign sel = fwd[grant];

  // Previous bus transfer came from the other port, or this beat was
  // parked: either way the burst no longer continues back-to-back.
  always_comb begin
    M_HTRANS = HTRANS_IDLE;
    if (req[grant])
      M_HTRANS = seq_fix(sel[1:0], pend[grant] | (grant != grant_q));
  end

  assign M_HADDR     = sel[ADDR_W+1:2];
  assign M_HWRITE    = sel[ADDR_W+2];
  assign M_HSIZE     = sel[ADDR_W+5:ADDR_W+3];
  assign M_HBURST    = sel[ADDR_W+8:ADDR_W+6];
  assign M_HPROT     = sel[ADDR_W+12:ADDR_W+9];
  assign M_HMASTLOCK = sel[ADDR_W+13];
  assign M_HMASTER   = grant;
  assign M_HWDATA    = dp_owner ? P1_HWDATA : P0_HWDATA;

  assign P0_HREADY = hready[0];
  assign P1_HREADY = hready[1];
  assign P0_HRESP  = dp_mine[0] ? M_HRESP : HRESP_OKAY;
  assign P1_HRESP  = dp_mine[1] ? M_HRESP : HRESP_OKAY;
  assign P0_HRDATA = M_HRDATA;
  assign P1_HRDATA = M_HRDATA;

  // Everything here advances only when the bus accepts the address phase.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      grant_q  <= 1'b0;
      locked   <= 1'b0;
      dp_valid <= 1'b0;
      dp_owner <= 1'b0;
    end else if (M_HREADY) begin
      grant_q  <= grant;
      locked   <= M_HMASTLOCK & M_HTRANS[1];
      dp_valid <= M_HTRANS[1];
      dp_owner <= grant;
    end
  end

endmodule

// File: tb/tb_ahblite_master_arbiter.sv
// Bench for ahblite_master_arbiter: directed scenarios with fixed expected
// values, then random traffic checked each cycle against a transfer-level
// reference model (parked transfers, data-phase owner, last owner, lock).
module tb_ahblite_master_arbiter;

`ifdef AHBLITE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  ht;
    logic [31:0] a;
    logic        w;
    logic [2:0]  sz;
    logic [2:0]  bu;
    logic [3:0]  pr;
    logic        lk;
  } xfer_t;

  logic HCLK = 1'b0, HRESETn = 1'b0;
  xfer_t [1:0]       lv = '0;
  logic  [1:0][31:0] wd = '0;
  logic        m_rdy = 1'b1, m_resp = 1'b0;
  logic [31:0] m_rd = '0;

  logic        P0_HREADY, P0_HRESP, P1_HREADY, P1_HRESP;
  logic [31:0] P0_HRDATA, P1_HRDATA;
  logic [1:0]  M_HTRANS;
  logic [31:0] M_HADDR, M_HWDATA;
  logic        M_HWRITE, M_HMASTLOCK, M_HMASTER;
  logic [2:0]  M_HSIZE, M_HBURST;
  logic [3:0]  M_HPROT;

  ahblite_master_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .P0_HTRANS(lv[0].ht), .P0_HADDR(lv[0].a), .P0_HWRITE(lv[0].w), .P0_HSIZE(lv[0].sz),
    .P0_HBURST(lv[0].bu), .P0_HPROT(lv[0].pr), .P0_HMASTLOCK(lv[0].lk), .P0_HWDATA(wd[0]),
    .P0_HREADY(P0_HREADY), .P0_HRESP(P0_HRESP), .P0_HRDATA(P0_HRDATA),
    .P1_HTRANS(lv[1].ht), .P1_HADDR(lv[1].a), .P1_HWRITE(lv[1].w), .P1_HSIZE(lv[1].sz),
    .P1_HBURST(lv[1].bu), .P1_HPROT(lv[1].pr), .P1_HMASTLOCK(lv[1].lk), .P1_HWDATA(wd[1]),
    .P1_HREADY(P1_HREADY), .P1_HRESP(P1_HRESP), .P1_HRDATA(P1_HRDATA),
    .M_HTRANS(M_HTRANS), .M_HADDR(M_HADDR), .M_HWRITE(M_HWRITE), .M_HSIZE(M_HSIZE),
    .M_HBURST(M_HBURST), .M_HPROT(M_HPROT), .M_HMASTLOCK(M_HMASTLOCK), .M_HWDATA(M_HWDATA),
    .M_HREADY(m_rdy), .M_HRESP(m_resp), .M_HRDATA(m_rd), .M_HMASTER(M_HMASTER)
  );

  always #5 HCLK = ~HCLK;

  int nchk = 0, nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state: which ports have a parked transfer and what it
  // is, who owns the data phase, who last had the address phase, lock.
  logic [1:0]  waiting = '0;
  xfer_t [1:0] parked  = '0;
  int          last = 0, downer = 0;
  bit          dvalid = 1'b0, lock = 1'b0;

  logic [1:0] e_rdy, e_resp, prev_rdy = 2'b11;
  int         e_mst;
  xfer_t      e_x;

  task automatic model_eval();
    logic [1:0] want;
    for (int n = 0; n < 2; n++) begin
      if (waiting[n])                     e_rdy[n] = 1'b0;
      else if (dvalid && downer == n)     e_rdy[n] = m_rdy;
      else                                e_rdy[n] = 1'b1;
      want[n]   = waiting[n] || (e_rdy[n] && lv[n].ht[1]);
      e_resp[n] = (dvalid && downer == n) ? m_resp : 1'b0;
    end
    if (lock)              e_mst = last;
    else if (want == 2'b11) e_mst = RR ? 1 - last : 0;
    else if (want[0])      e_mst = 0;
    else if (want[1])      e_mst = 1;
    else                   e_mst = last;
    e_x = waiting[e_mst] ? parked[e_mst] : lv[e_mst];
    if (!want[e_mst]) e_x.ht = 2'b00;
    else if (e_x.ht == 2'b11 && (waiting[e_mst] || e_mst != last)) e_x.ht = 2'b10;
  endtask

  task automatic model_update();
    if (!HRESETn) begin
      waiting = '0; last = 0; downer = 0; dvalid = 1'b0; lock = 1'b0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (e_mst == n && m_rdy) waiting[n] = 1'b0;
        else if (e_rdy[n] && lv[n].ht[1]) begin
          waiting[n] = 1'b1;
          parked[n]  = lv[n];
        end
      end
      if (m_rdy) begin
        dvalid = e_x.ht[1];
        downer = e_mst;
        last   = e_mst;
        lock   = e_x.lk && e_x.ht[1];
      end
    end
  endtask

  // Called at the negedge after inputs are set; checks and advances a cycle.
  task automatic step();
    #1;
    model_eval();
    chk("P0_HREADY", P0_HREADY, e_rdy[0]);
    chk("P1_HREADY", P1_HREADY, e_rdy[1]);
    chk("P0_HRESP", P0_HRESP, e_resp[0]);
    chk("P1_HRESP", P1_HRESP, e_resp[1]);
    chk("M_HMASTER", M_HMASTER, e_mst);
    chk("M_HTRANS", M_HTRANS, e_x.ht);
    if (e_x.ht != 2'b00)
      chk("M_addrphase", {M_HADDR, M_HWRITE, M_HSIZE, M_HBURST, M_HPROT, M_HMASTLOCK},
          {e_x.a, e_x.w, e_x.sz, e_x.bu, e_x.pr, e_x.lk});
    if (dvalid) chk("M_HWDATA", M_HWDATA, wd[downer]);
    chk("P1_HRDATA", P1_HRDATA, m_rd);
    prev_rdy = HRESETn ? e_rdy : 2'b11;
    model_update();
    @(negedge HCLK);
  endtask

  function automatic xfer_t rand_x();
    xfer_t x;
    int r = $urandom_range(0, 9);
    x.ht = (r < 3) ? 2'b00 : (r == 3) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
    x.a  = 32'h2000_0000 | ($urandom_range(0, 63) << 2);
    x.w  = 1'($urandom);
    x.sz = 3'($urandom);
    x.bu = 3'($urandom);
    x.pr = 4'($urandom);
    x.lk = ($urandom_range(0, 5) == 0);
    return x;
  endfunction

  initial begin
    HRESETn = 1'b0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Reset state
    #1;
    chk("rst_p0rdy", P0_HREADY, 1'b1);
    chk("rst_p1rdy", P1_HREADY, 1'b1);
    chk("rst_p0resp", P0_HRESP, 1'b0);
    chk("rst_mmaster", M_HMASTER, 1'b0);
    chk("rst_htrans", M_HTRANS, 2'b00);
    step();

    // P0 alone: write 0xDEADBEEF to 0x2000_0000, one wait state
    lv[0] = '{ht: 2'b10, a: 32'h2000_0000, w: 1'b1, sz: 3'd2, bu: 3'd0, pr: 4'h3, lk: 1'b0};
    #1;
    chk("s1_addr", M_HADDR, 32'h2000_0000);
    chk("s1_htrans", M_HTRANS, 2'b10);
    chk("s1_p0rdy", P0_HREADY, 1'b1);
    step();
    lv[0] = '0; wd[0] = 32'hDEAD_BEEF; m_rdy = 1'b0;
    #1;
    chk("s1_wdata", M_HWDATA, 32'hDEAD_BEEF);
    chk("s1_p0wait", P0_HREADY, 1'b0);
    step();
    m_rdy = 1'b1;
    #1;
    chk("s1_p0done", P0_HREADY, 1'b1);
    step();

`ifndef AHBLITE_ARB_RR_EN
    // Simultaneous NONSEQ reads: P0 first, P1 from hold, P1 gets data
    lv[0] = '{ht: 2'b10, a: 32'h2000_0100, w: 1'b0, sz: 3'd2, bu: 3'd0, pr: 4'h1, lk: 1'b0};
    lv[1] = '{ht: 2'b10, a: 32'h2000_0004, w: 1'b0, sz: 3'd2, bu: 3'd0, pr: 4'h1, lk: 1'b0};
    #1;
    chk("s2_master0", M_HMASTER, 1'b0);
    chk("s2_addr0", M_HADDR, 32'h2000_0100);
    step();
    lv = '0;
    #1;
    chk("s2_p1stall", P1_HREADY, 1'b0);
    chk("s2_master1", M_HMASTER, 1'b1);
    chk("s2_addr1", M_HADDR, 32'h2000_0004);
    chk("s2_htrans1", M_HTRANS, 2'b10);
    step();
    m_rd = 32'hCAFE_0001;
    #1;
    chk("s2_p1rdy", P1_HREADY, 1'b1);
    chk("s2_p1data", P1_HRDATA, 32'hCAFE_0001);
    step();
`endif

    // Continuous requests from both ports
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 2; n++)
        if (prev_rdy[n])
          lv[n] = '{ht: 2'b10, a: 32'h2000_0200 + 32'(k * 8 + n * 4), w: 1'b0,
                    sz: 3'd2, bu: 3'd0, pr: 4'h1, lk: 1'b0};
      #1;
      chk("alt_master", M_HMASTER, (RR && (k % 2 == 0)) ? 1'b1 : 1'b0);
      step();
    end

    // Random traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (prev_rdy[n]) lv[n] = rand_x();
        wd[n] = $urandom;
      end
      m_rdy   = ($urandom_range(0, 3) != 0);
      m_resp  = ($urandom_range(0, 7) == 0);
      m_rd    = $urandom;
      HRESETn = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
